// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for an approximate adder: accumulates squared/absolute error over a run.
// Optional max-error tracking (max_abs_err, max_in1, max_in2) is compiled in by ERR_MONITOR_MAX_EN.
module approx_err_monitor #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [WIDTH:0]   Out,
    output logic [ACC_W-1:0] sum_sq_err,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             done,
    output logic             busy
`ifdef ERR_MONITOR_MAX_EN
    ,
    output logic [WIDTH:0]   max_abs_err,
    output logic [WIDTH-1:0] max_in1,
    output logic [WIDTH-1:0] max_in2
`endif
);
    localparam int PW = 2 * (WIDTH + 2);
    localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] n_lat, acc_cnt;
    logic accept, last, launch, zero_res;

    assign in_ready = (state == RUN) && (acc_cnt < n_lat);
    assign accept   = in_valid && in_ready;
    assign last     = accept && (acc_cnt + CNT_W'(1) == n_lat);
    assign launch   = start && !clear && (state == IDLE || state == DONE);
    assign zero_res = clear || launch;
    assign done     = (state == DONE);
    assign busy     = (state == RUN) || (state == DRAIN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (last || acc_cnt >= n_lat) state_nxt = DRAIN;
            // No accepts in DRAIN, so stage 1 retires during this single cycle.
            DRAIN:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            n_lat   <= '0;
            acc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                acc_cnt <= '0;
            end else if (launch) begin
                n_lat   <= num_samples;
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1: exact sum and signed error
    logic [WIDTH:0]          exact_c, s1_exact;
    logic signed [WIDTH+1:0] err_c, s1_err;
    logic                    s1_vld;

    assign exact_c = {1'b0, IN1} + {1'b0, IN2};
    assign err_c   = $signed({1'b0, Out}) - $signed({1'b0, exact_c});

`ifdef ERR_MONITOR_MAX_EN
    logic [WIDTH-1:0] s1_in1, s1_in2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_in1 <= '0;
            s1_in2 <= '0;
        end else if (accept) begin
            s1_in1 <= IN1;
            s1_in2 <= IN2;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_exact <= '0;
            s1_err   <= '0;
        end else begin
            s1_vld <= accept && !clear;
            if (accept) begin
                s1_exact <= exact_c;
                s1_err   <= err_c;
            end
        end
    end

    // Stage 2: saturating accumulation
    logic signed [PW-1:0] err_x;
    logic [PW-1:0]        sq;
    logic [WIDTH:0]       abs_e;
    logic [SW-1:0]        sq_sum, ab_sum;

    always_comb begin
        err_x  = PW'(s1_err);
        sq     = $unsigned(err_x * err_x);
        abs_e  = s1_err[WIDTH+1] ? (WIDTH+1)'(-s1_err) : (WIDTH+1)'(s1_err);
        sq_sum = SW'(sum_sq_err) + SW'(sq);
        ab_sum = SW'(sum_abs_err) + SW'(abs_e);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_sq_err  <= '0;
            sum_abs_err <= '0;
            err_cnt     <= '0;
            sample_cnt  <= '0;
        end else if (zero_res) begin
            sum_sq_err  <= '0;
            sum_abs_err <= '0;
            err_cnt     <= '0;
            sample_cnt  <= '0;
        end else if (s1_vld) begin
            sum_sq_err  <= (sq_sum > SW'(ACC_MAX)) ? ACC_MAX : sq_sum[ACC_W-1:0];
            sum_abs_err <= (ab_sum > SW'(ACC_MAX)) ? ACC_MAX : ab_sum[ACC_W-1:0];
            if (s1_err != '0 && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
            if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

`ifdef ERR_MONITOR_MAX_EN
    // Strict compare keeps the first sample that reached the maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_abs_err <= '0;
            max_in1     <= '0;
            max_in2     <= '0;
        end else if (zero_res) begin
            max_abs_err <= '0;
            max_in1     <= '0;
            max_in2     <= '0;
        end else if (s1_vld && abs_e > max_abs_err) begin
            max_abs_err <= abs_e;
            max_in1     <= s1_in1;
            max_in2     <= s1_in2;
        end
    end
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench for approx_err_monitor; ACC_W is narrowed so accumulator saturation is reachable.
// Max-error checks are compiled in with ERR_MONITOR_MAX_EN.
module tb_approx_err_monitor;
    localparam int WIDTH = 16;
    localparam int ACC_W = 20;
    localparam int CNT_W = 32;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

    logic clk, rst, start, clear, in_valid, in_ready, done, busy;
    logic [CNT_W-1:0] num_samples, err_cnt, sample_cnt;
    logic [WIDTH-1:0] IN1, IN2;
    logic [WIDTH:0]   Out;
    logic [ACC_W-1:0] sum_sq_err, sum_abs_err;
`ifdef ERR_MONITOR_MAX_EN
    logic [WIDTH:0]   max_abs_err;
    logic [WIDTH-1:0] max_in1, max_in2;
`endif

    approx_err_monitor #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .IN1(IN1), .IN2(IN2), .Out(Out),
        .sum_sq_err(sum_sq_err), .sum_abs_err(sum_abs_err), .err_cnt(err_cnt),
        .sample_cnt(sample_cnt), .done(done), .busy(busy)
`ifdef ERR_MONITOR_MAX_EN
        , .max_abs_err(max_abs_err), .max_in1(max_in1), .max_in2(max_in2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { longint sq; longint ab; int nz; } sb_t;
    sb_t sbq[$];
    int passed = 0;
    int total  = 0;

    // Monitor owns the running model; it pops one entry per visible sample.
    longint exp_sq, exp_ab;
    int exp_nz, exp_n;
    logic [CNT_W-1:0] prev_cnt;
    initial begin
        exp_sq = 0; exp_ab = 0; exp_nz = 0; exp_n = 0; prev_cnt = '0;
        forever begin
            sb_t e;
            @(posedge clk);
            #2;
            if (rst) begin
                prev_cnt = '0;
                exp_sq = 0; exp_ab = 0; exp_nz = 0; exp_n = 0;
            end else begin
                if (sample_cnt == prev_cnt + 1) begin
                    total++;
                    if (sbq.size() == 0) begin
                        $display("FAIL sb_extra: sample_cnt=%0d with no sample expected", sample_cnt);
                    end else begin
                        e = sbq.pop_front();
                        exp_sq = (exp_sq + e.sq > ACC_MAX) ? ACC_MAX : exp_sq + e.sq;
                        exp_ab = (exp_ab + e.ab > ACC_MAX) ? ACC_MAX : exp_ab + e.ab;
                        exp_nz += e.nz;
                        exp_n++;
                        if ({sum_sq_err, sum_abs_err, err_cnt, sample_cnt} !==
                            {ACC_W'(exp_sq), ACC_W'(exp_ab), CNT_W'(exp_nz), CNT_W'(exp_n)})
                            $display("FAIL sb_sample: got sq=%0d ab=%0d nz=%0d n=%0d want sq=%0d ab=%0d nz=%0d n=%0d",
                                     sum_sq_err, sum_abs_err, err_cnt, sample_cnt, exp_sq, exp_ab, exp_nz, exp_n);
                        else passed++;
                    end
                end else if (sample_cnt != prev_cnt) begin
                    total++;
                    if (sample_cnt !== '0)
                        $display("FAIL sb_jump: sample_cnt %0d -> %0d", prev_cnt, sample_cnt);
                    else passed++;
                    exp_sq = 0; exp_ab = 0; exp_nz = 0; exp_n = 0;
                end
                prev_cnt = sample_cnt;
            end
        end
    end

    task automatic pulse_start(input logic [CNT_W-1:0] n);
        start = 1'b1; num_samples = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [WIDTH-1:0] a, b, input logic [WIDTH:0] o, input logic v,
                        output logic acc);
        sb_t e;
        longint err;
        IN1 = a; IN2 = b; Out = o; in_valid = v;
        acc = v && in_ready;
        if (acc) begin
            err = longint'(o) - (longint'(a) + longint'(b));
            e.sq = err * err;
            e.ab = (err < 0) ? -err : err;
            e.nz = (err != 0) ? 1 : 0;
            sbq.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        #3;
        total++;
        if ({in_ready, done, busy} !== 3'b000)
            $display("FAIL reset_ctrl: ready/done/busy=%b want 000", {in_ready, done, busy});
        else passed++;
        total++;
        if ({sum_sq_err, sum_abs_err, err_cnt, sample_cnt} !== '0)
            $display("FAIL reset_results: sq=%0d ab=%0d nz=%0d n=%0d want all 0",
                     sum_sq_err, sum_abs_err, err_cnt, sample_cnt);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic acc;
        int cyc;
        pulse_start(1);
        feed('0, '0, 17'h100, 1'b1, acc);
        wait_done(cyc);
        total++;
        if (cyc != 1) $display("FAIL single_latency: done after %0d cycles want 1", cyc);
        else passed++;
        total++;
        if ({sum_sq_err, sum_abs_err, err_cnt, sample_cnt} !==
            {ACC_W'(65536), ACC_W'(256), CNT_W'(1), CNT_W'(1)})
            $display("FAIL single_result: sq=%0d ab=%0d nz=%0d n=%0d want 65536 256 1 1",
                     sum_sq_err, sum_abs_err, err_cnt, sample_cnt);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL single_busy: busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_multi;
        logic acc;
        int cyc;
        pulse_start(3);
        feed(16'd5, 16'd7, 17'd12, 1'b1, acc);
        feed(16'hFFFF, 16'd1, 17'h10000, 1'b1, acc);
        feed(16'd3, 16'd4, 17'd6, 1'b1, acc);
        wait_done(cyc);
        total++;
        if ({sum_sq_err, sum_abs_err, err_cnt, sample_cnt} !==
            {ACC_W'(1), ACC_W'(1), CNT_W'(1), CNT_W'(3)})
            $display("FAIL multi_result: sq=%0d ab=%0d nz=%0d n=%0d want 1 1 1 3",
                     sum_sq_err, sum_abs_err, err_cnt, sample_cnt);
        else passed++;
        // Results hold in DONE while start stays low
        repeat (3) @(negedge clk);
        total++;
        if ({done, sum_sq_err, sample_cnt} !== {1'b1, ACC_W'(1), CNT_W'(3)})
            $display("FAIL multi_hold: done=%b sq=%0d n=%0d want 1 1 3", done, sum_sq_err, sample_cnt);
        else passed++;
    endtask

    task automatic test_toggle;
        logic acc;
        int accepts = 0;
        int i = 0;
        logic [WIDTH-1:0] a, b;
        pulse_start(4);
        while (accepts < 4 && i < 20) begin
            a = WIDTH'($urandom_range(0, 16'hFFFF));
            b = WIDTH'($urandom_range(0, 16'hFFFF));
            feed(a, b, (WIDTH+1)'({1'b0, a} + {1'b0, b} + 17'($urandom_range(0, 3))), (i % 2) == 0, acc);
            if (acc) accepts++;
            i++;
        end
        total++;
        if (accepts != 4 || i != 7) $display("FAIL toggle_accepts: %0d accepts in %0d cycles want 4 in 7", accepts, i);
        else passed++;
        total++;
        if ({in_ready, done, busy} !== 3'b001)
            $display("FAIL toggle_after_last: ready/done/busy=%b want 001", {in_ready, done, busy});
        else passed++;
        @(negedge clk);
        total++;
        if ({done, sample_cnt} !== {1'b1, CNT_W'(4)})
            $display("FAIL toggle_done: done=%b n=%0d want 1 4 two cycles after last accept", done, sample_cnt);
        else passed++;
    endtask

    task automatic test_zero;
        logic acc;
        int accepts = 0;
        pulse_start(0);
        repeat (2) begin
            feed(16'd1, 16'd1, 17'd9, 1'b1, acc);
            if (acc) accepts++;
        end
        total++;
        if (done !== 1'b1 || accepts != 0)
            $display("FAIL zero_done: done=%b accepts=%0d want 1 0", done, accepts);
        else passed++;
        total++;
        if ({sum_sq_err, sum_abs_err, err_cnt, sample_cnt} !== '0)
            $display("FAIL zero_results: sq=%0d ab=%0d nz=%0d n=%0d want all 0",
                     sum_sq_err, sum_abs_err, err_cnt, sample_cnt);
        else passed++;
    endtask

    task automatic test_saturate;
        logic acc;
        int cyc;
        pulse_start(17);
        repeat (17) feed('0, '0, 17'h100, 1'b1, acc);
        wait_done(cyc);
        total++;
        if ({sum_sq_err, sum_abs_err, err_cnt, sample_cnt} !==
            {ACC_W'(ACC_MAX), ACC_W'(4352), CNT_W'(17), CNT_W'(17)})
            $display("FAIL sat_result: sq=%0d ab=%0d nz=%0d n=%0d want %0d 4352 17 17",
                     sum_sq_err, sum_abs_err, err_cnt, sample_cnt, ACC_MAX);
        else passed++;
    endtask

    task automatic test_clear_start;
        logic acc;
        int accepts = 0;
        pulse_start(5);
        feed(16'd10, 16'd10, 17'd25, 1'b1, acc);
        feed(16'd10, 16'd10, 17'd30, 1'b1, acc);
        clear = 1'b1; start = 1'b1; num_samples = 7;
        sbq.delete();
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        total++;
        if ({in_ready, done, busy} !== 3'b000)
            $display("FAIL clear_ctrl: ready/done/busy=%b want 000", {in_ready, done, busy});
        else passed++;
        repeat (3) begin
            feed(16'd1, 16'd2, 17'd7, 1'b1, acc);
            if (acc) accepts++;
        end
        total++;
        if ({busy, sum_sq_err, sum_abs_err, err_cnt, sample_cnt} !== '0 || accepts != 0)
            $display("FAIL clear_results: busy=%b sq=%0d ab=%0d nz=%0d n=%0d accepts=%0d want all 0",
                     busy, sum_sq_err, sum_abs_err, err_cnt, sample_cnt, accepts);
        else passed++;
    endtask

    task automatic test_rst_drain;
        logic acc;
        pulse_start(1);
        feed(16'd1, 16'd1, 17'd40, 1'b1, acc);
        total++;
        if (busy !== 1'b1) $display("FAIL rst_pre_drain: busy=%b want 1", busy);
        else passed++;
        rst = 1'b1;
        sbq.delete();
        #1;
        total++;
        if ({in_ready, done, busy} !== 3'b000)
            $display("FAIL rst_async: ready/done/busy=%b want 000", {in_ready, done, busy});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({done, busy, sum_sq_err, sum_abs_err, err_cnt, sample_cnt} !== '0)
            $display("FAIL rst_discard: done=%b busy=%b sq=%0d ab=%0d nz=%0d n=%0d want all 0",
                     done, busy, sum_sq_err, sum_abs_err, err_cnt, sample_cnt);
        else passed++;
    endtask

`ifdef ERR_MONITOR_MAX_EN
    task automatic test_max;
        logic acc;
        int cyc;
        pulse_start(2);
        feed(16'd0, 16'd3, 17'd0, 1'b1, acc);
        feed(16'd5, 16'd0, 17'd8, 1'b1, acc);
        wait_done(cyc);
        total++;
        if ({max_abs_err, max_in1, max_in2} !== {17'd3, 16'd0, 16'd3})
            $display("FAIL max_track: max=%0d in1=%0d in2=%0d want 3 0 3", max_abs_err, max_in1, max_in2);
        else passed++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        total++;
        if ({max_abs_err, max_in1, max_in2} !== '0)
            $display("FAIL max_clear: max=%0d in1=%0d in2=%0d want 0", max_abs_err, max_in1, max_in2);
        else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; num_samples = '0;
        in_valid = 1'b0; IN1 = '0; IN2 = '0; Out = '0;
        test_reset();
        test_single();
        test_multi();
        test_toggle();
        test_zero();
        test_saturate();
        test_clear_start();
        test_rst_drain();
`ifdef ERR_MONITOR_MAX_EN
        test_max();
`endif
        repeat (3) @(negedge clk);
        total++;
        if (sbq.size() != 0) $display("FAIL sb_drain: %0d samples never retired want 0", sbq.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
